// File: rtl/pu_layer_sequencer_pkg.sv
// Shared definitions for the PU layer sequencer: data widths, FSM state
// encoding and the address-width helper used by the top and its interface.
package pu_pkg;

    localparam int WORD_W = 32;
    localparam int VEC_W  = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETTLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Weight-set index width; a single neuron still needs a 1-bit address.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pu_layer_sequencer_if.sv
// Bus bundle between the sequencer and its environment (run control, weight
// memory, external PU and the result stream). The sequencer connects through
// the master modport; the environment side uses slave.
interface pu_layer_sequencer_if
    import pu_pkg::*;
#(
    parameter int AW = 3
);

    logic              start;
    logic [VEC_W-1:0]  x_in;
    logic              w_rd;
    logic [AW-1:0]     w_addr;
    logic [VEC_W-1:0]  w_data;
    logic [VEC_W-1:0]  pu_x;
    logic [VEC_W-1:0]  pu_w;
    logic [WORD_W-1:0] pu_result;
    logic              y_valid;
    logic [AW-1:0]     y_idx;
    logic [WORD_W-1:0] y_data;
    logic              y_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, x_in, w_data, pu_result, y_ready,
        output w_rd, w_addr, pu_x, pu_w, y_valid, y_idx, y_data, busy, done
    );

    modport slave (
        output start, x_in, w_data, pu_result, y_ready,
        input  w_rd, w_addr, pu_x, pu_w, y_valid, y_idx, y_data, busy, done
    );

endinterface

// File: rtl/pu_layer_sequencer_relu.sv
// Sign clamp applied to the PU result before it is captured: negative
// single-precision values (sign bit set) become +0.0, others pass unchanged.
module pu_relu
    import pu_pkg::*;
(
    input  logic [WORD_W-1:0] pu_result_i,
    output logic [WORD_W-1:0] y_data_o
);

    // Clamp on the IEEE-754 sign bit only; no arithmetic on the value.
    always_comb begin
        y_data_o = pu_result_i[WORD_W-1] ? '0 : pu_result_i;
    end

endmodule

// File: rtl/pu_layer_sequencer.sv
// Layer sequencer: for each neuron, fetches one weight set, presents it to an
// external PU alongside the run's input vector, waits PU_LATENCY cycles and
// streams the result out with a valid/ready handshake.
// Optional build macro: PU_RELU_EN inserts the pu_relu sign clamp on the
// captured result; without it the PU result is captured bit-exact.
module pu_layer_sequencer
    import pu_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int PU_LATENCY  = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    pu_layer_sequencer_if.master bus
);

    localparam int            AW       = addr_w(NUM_NEURONS);
    localparam int            CW       = 4;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PU_LATENCY - 1);

    state_t            state_q;
    logic [AW-1:0]     idx_q;
    logic [CW-1:0]     cnt_q;
    logic              w_rd_q;
    logic [VEC_W-1:0]  pu_x_q;
    logic [VEC_W-1:0]  pu_w_q;
    logic              y_valid_q;
    logic [AW-1:0]     y_idx_q;
    logic [WORD_W-1:0] y_data_q;
    logic [WORD_W-1:0] y_data_d;
    logic              busy_q;
    logic              done_q;

`ifdef PU_RELU_EN
    pu_relu u_relu (
        .pu_result_i (bus.pu_result),
        .y_data_o    (y_data_d)
    );
`else
    assign y_data_d = bus.pu_result;
`endif

    // Run FSM with all outputs registered; idx drives w_addr directly, so the
    // address is already valid in the cycle the read strobe is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            w_rd_q    <= 1'b0;
            pu_x_q    <= '0;
            pu_w_q    <= '0;
            y_valid_q <= 1'b0;
            y_idx_q   <= '0;
            y_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        pu_x_q  <= bus.x_in;
                        idx_q   <= '0;
                        w_rd_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    w_rd_q  <= 1'b0;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    pu_w_q  <= bus.w_data;
                    cnt_q   <= '0;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == LAST_CNT) begin
                        y_data_q  <= y_data_d;
                        y_idx_q   <= idx_q;
                        y_valid_q <= 1'b1;
                        state_q   <= ST_EMIT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_EMIT: begin
                    if (bus.y_ready) begin
                        y_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            w_rd_q  <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.w_rd    = w_rd_q;
    assign bus.w_addr  = idx_q;
    assign bus.pu_x    = pu_x_q;
    assign bus.pu_w    = pu_w_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_idx   = y_idx_q;
    assign bus.y_data  = y_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_pu_layer_sequencer.sv
// Bench for pu_layer_sequencer: instance A (4 neurons, latency 1) and
// instance B (1 neuron, latency 3), each with its own weight memory and PU
// model. Expected values come from a cycle-position model and a reference
// weighted-sum function. Honours PU_RELU_EN when defined.
module tb_pu_layer_sequencer;
    import pu_pkg::*;

    localparam int NA = 4;
    localparam int LA = 1;
    localparam int NB = 1;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    pu_layer_sequencer_if #(.AW(2)) bus_a ();
    pu_layer_sequencer_if #(.AW(1)) bus_b ();

    pu_layer_sequencer #(.NUM_NEURONS(NA), .PU_LATENCY(LA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    pu_layer_sequencer #(.NUM_NEURONS(NB), .PU_LATENCY(LB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    logic [VEC_W-1:0] mem_a [NA];
    logic [VEC_W-1:0] mem_b;

    function automatic logic [VEC_W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // PU stand-in: wrapping sum of the four lanes of x ^ w.
    function automatic logic [31:0] pu_fn(input logic [127:0] x, input logic [127:0] w);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s += x[32*i +: 32] ^ w[32*i +: 32];
        return s;
    endfunction

    function automatic logic [31:0] ref_y(input logic [31:0] v);
`ifdef PU_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Weight memories: data valid only in the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        bus_a.w_data <= bus_a.w_rd ? mem_a[bus_a.w_addr] : rnd128();
        bus_b.w_data <= bus_b.w_rd ? mem_b : rnd128();
    end

    // PU models: A settles within one cycle; B needs three (two register stages).
    logic [31:0] pb0, pb1;
    assign bus_a.pu_result = pu_fn(bus_a.pu_x, bus_a.pu_w);
    always @(posedge clk) begin
        pb0 <= pu_fn(bus_b.pu_x, bus_b.pu_w);
        pb1 <= pb0;
    end
    assign bus_b.pu_result = pb1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_w_rd"}, bus_a.w_rd, 0);
        chk({tag, "_w_addr"}, bus_a.w_addr, 0);
        chk({tag, "_pu_x"}, bus_a.pu_x, 0);
        chk({tag, "_pu_w"}, bus_a.pu_w, 0);
        chk({tag, "_y_valid"}, bus_a.y_valid, 0);
        chk({tag, "_y_idx"}, bus_a.y_idx, 0);
        chk({tag, "_y_data"}, bus_a.y_data, 0);
        chk({tag, "_busy"}, bus_a.busy, 0);
        chk({tag, "_done"}, bus_a.done, 0);
    endtask

    task automatic rand_mem_a();
        for (int i = 0; i < NA; i++) mem_a[i] = rnd128();
    endtask

    // Full run on A with y_ready held high, checked cycle by cycle against the
    // expected event positions; poke=1 also pulses start in SETTLE and DONE.
    task automatic run_timed(input logic [127:0] x, input bit poke);
        int unsigned per;
        int unsigned last;
        bit ev, erd, edn, ebz;
        per  = LA + 3;
        last = per * NA + 2;
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.x_in    = x;
        bus_a.y_ready = 1'b1;
        for (int unsigned k = 1; k <= last; k++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            ev  = (k % per == 0) && (k / per >= 1) && (k / per <= NA);
            erd = (k % per == 1) && (k / per < NA);
            edn = (k == per * NA + 1);
            ebz = (k <= per * NA + 1);
            chk("t_y_valid", bus_a.y_valid, ev);
            chk("t_w_rd", bus_a.w_rd, erd);
            chk("t_done", bus_a.done, edn);
            chk("t_busy", bus_a.busy, ebz);
            chk("t_pu_x", bus_a.pu_x, x);
            if (ev) begin
                chk("t_y_idx", bus_a.y_idx, k / per - 1);
                chk("t_y_data", bus_a.y_data, ref_y(pu_fn(x, mem_a[k / per - 1])));
            end
            if (erd) chk("t_w_addr", bus_a.w_addr, k / per);
            if (poke && (k == 3 || k == per * NA + 1)) begin
                bus_a.start = 1'b1;
                bus_a.x_in  = ~x;
            end
        end
    endtask

    // Run on A with random back-pressure; hold10 forces a 10-cycle stall on the
    // first result. Results are checked in order at each transfer.
    task automatic run_stall(input logic [127:0] x, input bit hold10, input int unsigned pct);
        int unsigned got;
        int unsigned stall_left;
        bit done_seen, stall_prev, held;
        logic [31:0] prev_d;
        logic [1:0] prev_i;
        got = 0; stall_left = 0; done_seen = 0; stall_prev = 0; held = 0;
        prev_d = '0; prev_i = '0;
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.x_in    = x;
        bus_a.y_ready = 1'b0;
        for (int unsigned c = 0; c < 400 && !done_seen; c++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            if (stall_prev) begin
                chk("s_hold_valid", bus_a.y_valid, 1);
                chk("s_hold_data", bus_a.y_data, prev_d);
                chk("s_hold_idx", bus_a.y_idx, prev_i);
                chk("s_no_rd", bus_a.w_rd, 0);
            end
            if (bus_a.done) begin
                done_seen = 1;
                chk("s_count", got, NA);
            end
            if (hold10 && !held && bus_a.y_valid) begin
                held = 1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                bus_a.y_ready = 1'b0;
                stall_left--;
            end else begin
                bus_a.y_ready = ($urandom_range(0, 99) >= pct);
            end
            stall_prev = 0;
            if (bus_a.y_valid) begin
                if (bus_a.y_ready) begin
                    chk("s_y_idx", bus_a.y_idx, got);
                    chk("s_y_data", bus_a.y_data, ref_y(pu_fn(x, mem_a[got % NA])));
                    chk("s_pu_w", bus_a.pu_w, mem_a[got % NA]);
                    got++;
                end else begin
                    stall_prev = 1;
                    prev_d = bus_a.y_data;
                    prev_i = bus_a.y_idx;
                end
            end
        end
        if (!done_seen) chk("s_done_timeout", 0, 1);
        @(negedge clk);
        chk("s_busy_after", bus_a.busy, 0);
        chk("s_done_after", bus_a.done, 0);
    endtask

    initial begin
        logic [127:0] xb;
        bus_a.start = 1'b0; bus_a.x_in = '0; bus_a.y_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.x_in = '0; bus_b.y_ready = 1'b0;
        rand_mem_a();
        mem_b = rnd128();

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero_a("rst_a");
        chk("rst_b_busy", bus_b.busy, 0);
        chk("rst_b_valid", bus_b.y_valid, 0);
        chk("rst_b_w_rd", bus_b.w_rd, 0);
        rst_n = 1'b1;

        // Known PU outputs 1.0+idx with zero input vector
        for (int i = 0; i < NA; i++) mem_a[i] = {96'h0, 32'h3F800000 + 32'(i)};
        run_timed('0, 0);

        // Random vectors, always ready
        repeat (3) begin
            rand_mem_a();
            run_timed(rnd128(), 0);
        end

        // Stray starts in SETTLE and DONE are dropped
        rand_mem_a();
        run_timed(rnd128(), 1);

        // Back-pressure: directed 10-cycle stall, then random stalls
        rand_mem_a();
        run_stall(rnd128(), 1, 30);
        repeat (3) begin
            rand_mem_a();
            run_stall(rnd128(), 0, 50);
        end

        // Sign handling of the captured result
        rand_mem_a();
        mem_a[0] = {96'h0, 32'hC0400000};
        mem_a[1] = {96'h0, 32'h40000000};
        run_timed('0, 0);

        // Asynchronous reset during SETTLE of neuron 2, then a fresh run
        rand_mem_a();
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.x_in = rnd128(); bus_a.y_ready = 1'b1;
        repeat (11) begin
            @(negedge clk);
            bus_a.start = 1'b0;
        end
        chk("mid_busy", bus_a.busy, 1);
        chk("mid_pu_w", bus_a.pu_w, mem_a[2]);
        #1 rst_n = 1'b0;
        #1 chk_zero_a("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_timed(rnd128(), 0);

        // Instance B: single neuron, latency 3
        xb = rnd128();
        @(negedge clk);
        bus_b.start = 1'b1; bus_b.x_in = xb; bus_b.y_ready = 1'b1;
        for (int unsigned k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            chk("b_w_rd", bus_b.w_rd, k == 1);
            chk("b_y_valid", bus_b.y_valid, k == 6);
            chk("b_done", bus_b.done, k == 7);
            chk("b_busy", bus_b.busy, k <= 7);
            if (k == 6) begin
                chk("b_y_idx", bus_b.y_idx, 0);
                chk("b_y_data", bus_b.y_data, ref_y(pu_fn(xb, mem_b)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pu_layer_sequencer.md
PU_LAYER_SEQUENCER -- requirements
Module: pu_layer_sequencer

Interface
REQ-001 Parameter NUM_NEURONS, default 8: number of weight sets (neurons) evaluated per run; range 1..256.
REQ-002 Parameter PU_LATENCY, default 1: cycles from PU operand update to a stable pu_result; range 1..15.
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle run request, sampled in IDLE only.
REQ-007 x_in  in  128  four IEEE-754 single operands {x4,x3,x2,x1}, sampled with start.
REQ-008 w_rd  out  1  weight-memory read strobe.
REQ-009 w_addr  out  clog2(NUM_NEURONS) (min 1)  weight-set index.
REQ-010 w_data  in  128  {w4,w3,w2,w1}, valid exactly one cycle after w_rd.
REQ-011 pu_x, pu_w  out  128 each  registered PU operands.
REQ-012 pu_result  in  32  PU weighted-sum output.
REQ-013 y_valid  out  1; y_idx  out  width of w_addr; y_data  out  32: result stream.
REQ-014 y_ready  in  1  consumer ready; a transfer occurs when y_valid and y_ready are both high.
REQ-015 busy  out  1  high in every state except IDLE; done  out  1  one-cycle pulse at end of run.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, LOAD, SETTLE, EMIT and DONE.
REQ-017 IDLE + start: latch x_in into pu_x, set idx=0, assert w_rd with w_addr=0, go to FETCH.
REQ-018 FETCH: deassert w_rd, go to LOAD.
REQ-019 LOAD: latch w_data into pu_w, clear the settle counter, go to SETTLE.
REQ-020 SETTLE: count PU_LATENCY cycles; on the last count, register pu_result into y_data, set y_idx=idx and y_valid=1, go to EMIT.
REQ-021 EMIT: hold y_valid, y_data and y_idx stable until the transfer, which may be stalled indefinitely.
REQ-022 On a transfer with idx < NUM_NEURONS-1: increment idx, assert w_rd with the new w_addr, clear y_valid in that same cycle, go to FETCH.
REQ-023 On a transfer with idx = NUM_NEURONS-1: clear y_valid and go to DONE; DONE asserts done for one cycle, then returns to IDLE; idx does not wrap.
REQ-024 Per-neuron cost with y_ready held high: PU_LATENCY+3 cycles; start-to-first-y_valid is PU_LATENCY+3 cycles.
REQ-025 start SHALL be ignored in every state except IDLE; a start during DONE is dropped.
REQ-026 pu_x SHALL stay constant for the entire run; pu_w SHALL change only in LOAD.
REQ-027 y_data SHALL be a bit-exact copy of pu_result; the block performs no arithmetic on it.
REQ-028 With NUM_NEURONS=1: exactly one result is emitted, then DONE.

Reset
REQ-029 Reset assertion SHALL force IDLE immediately, including mid-run; no partial-run state is retained.
REQ-030 Reset values: every output is 0, with w_rd=0, y_valid=0, busy=0 and done=0; idx and the settle counter are also 0.

Configuration
REQ-031 Macro PU_RELU_EN controls the ReLU stage.
- When defined, the value captured into y_data is 32'h0 whenever pu_result[31]=1; otherwise pu_result is passed unchanged.
- When undefined, y_data = pu_result in all cases, and no ReLU logic is synthesized.

Structure
REQ-032 The shared package pu_pkg SHALL hold WORD_W=32, VEC_W=128 and the FSM state enum.
REQ-033 One sub-module, pu_relu (combinational sign clamp), SHALL be instantiated only under PU_RELU_EN; the PU itself is external, connected through the pu_* ports.

Verification
REQ-034 NUM_NEURONS=4, PU_LATENCY=1, y_ready=1, bench PU model returns 32'h3F800000+idx -> four results, y_idx 0..3, each 4 cycles apart, then a done pulse; busy falls on the cycle after done.
REQ-035 y_ready held low for 10 cycles in EMIT -> y_valid, y_data and y_idx are held stable; no w_rd is issued until y_ready rises.
REQ-036 start pulsed during SETTLE and again during DONE -> both ignored; exactly NUM_NEURONS results are emitted.
REQ-037 rst_n asserted in SETTLE of neuron 2 -> all outputs 0 asynchronously; a new start runs from idx 0 with a fresh x_in.
REQ-038 PU_RELU_EN defined, pu_result=32'hC0400000 (-3.0) -> y_data=0; pu_result=32'h40000000 -> y_data=32'h40000000; with the macro undefined, -3.0 passes through unchanged.
REQ-039 PU_LATENCY=3, NUM_NEURONS=1 -> w_rd at cycle 1 after start, y_valid at cycle 6, done the cycle after the transfer.
